// File: rtl/elev_pkg.sv
// Shared constants and request-decode helpers for the three-floor elevator controller.
package elev_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int REQ_IN1     = 0;
    localparam int REQ_IN2     = 1;
    localparam int REQ_IN3     = 2;
    localparam int REQ_OUT1    = 3;
    localparam int REQ_OUT2_UP = 4;
    localparam int REQ_OUT2_DN = 5;
    localparam int REQ_OUT3    = 6;
    localparam int REQ_W       = 7;

    localparam logic [2:0] FLOOR_MIN = 3'd1;
    localparam logic [2:0] FLOOR_MAX = 3'd3;

    function automatic logic [REQ_W-1:0] floor_bits(input logic [2:0] f);
        logic [REQ_W-1:0] m;
        m = '0;
        case (f)
            3'd1: begin
                m[REQ_IN1]  = 1'b1;
                m[REQ_OUT1] = 1'b1;
            end
            3'd2: begin
                m[REQ_IN2]     = 1'b1;
                m[REQ_OUT2_UP] = 1'b1;
                m[REQ_OUT2_DN] = 1'b1;
            end
            3'd3: begin
                m[REQ_IN3]  = 1'b1;
                m[REQ_OUT3] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Request bits for every floor strictly beyond f in the given direction.
    function automatic logic [REQ_W-1:0] beyond_bits(input logic [2:0] f, input logic up);
        logic [REQ_W-1:0] m;
        m = '0;
        if (up) begin
            if (f == 3'd1)      m = floor_bits(3'd2) | floor_bits(3'd3);
            else if (f == 3'd2) m = floor_bits(3'd3);
        end else begin
            if (f == 3'd3)      m = floor_bits(3'd2) | floor_bits(3'd1);
            else if (f == 3'd2) m = floor_bits(3'd1);
        end
        return m;
    endfunction

    // Bits cleared when the door opens at floor f; nonzero means f is serviceable.
    function automatic logic [REQ_W-1:0] clear_mask(input logic [REQ_W-1:0] req,
                                                    input logic [2:0]       f,
                                                    input logic             up);
        logic [REQ_W-1:0] m;
        logic             ahead;
        logic             behind;
        logic             dep_up;
        ahead  = |(req & beyond_bits(f, up));
        behind = |(req & beyond_bits(f, !up));
        dep_up = (ahead || !behind) ? up : !up;
        m      = '0;
        if (f == 3'd2) begin
            m[REQ_IN2] = req[REQ_IN2];
            if (up || !ahead)  m[REQ_OUT2_UP] = req[REQ_OUT2_UP];
            if (!up || !ahead) m[REQ_OUT2_DN] = req[REQ_OUT2_DN];
            if (m[REQ_OUT2_UP] && m[REQ_OUT2_DN]) begin
                if (dep_up) m[REQ_OUT2_DN] = 1'b0;
                else        m[REQ_OUT2_UP] = 1'b0;
            end
        end else begin
            m = req & floor_bits(f);
        end
        return m;
    endfunction

endpackage

// File: rtl/elev_timer.sv
// 16-bit up-counter with restart and enable; o_tc flags the last count (LIMIT-1) while enabled.
module elev_timer #(
    parameter int unsigned LIMIT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_restart)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 16'd1;
    end

    assign o_tc = i_en && (r_cnt == LAST);

endmodule

// File: rtl/elevator_ctrl.sv
// Collective up/down elevator sequencer: request latch, floor register, IDLE/MOVE/DOOR FSM.
// Defining ELEV_DOOR_HOLD_EN adds door_hold_n, which pins the door timer at 0 while low.
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter int unsigned TRAVEL_CYC = 100,
    parameter int unsigned DOOR_CYC   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sp_inbtn1,
    input  logic       sp_inbtn2,
    input  logic       sp_inbtn3,
    input  logic       sp_outbtn1,
    input  logic       sp_outbtn2_up,
    input  logic       sp_outbtn2_down,
    input  logic       sp_outbtn3,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic       door_hold_n,
`endif
    output logic [2:0] story,
    output logic       turn_up,
    output logic       turn_down,
    output logic       door_open,
    output logic [6:0] req
);

    logic [1:0]       r_state;
    logic             r_dir;
    logic [2:0]       r_story;
    logic [REQ_W-1:0] r_req;

    logic [REQ_W-1:0] w_btn;
    logic [REQ_W-1:0] w_here_bits;
    logic [REQ_W-1:0] w_set;
    logic [REQ_W-1:0] w_clr;
    logic [REQ_W-1:0] w_clr_here;
    logic [REQ_W-1:0] w_clr_next;
    logic [2:0]       w_next_floor;
    logic             w_up;
    logic             w_ahead;
    logic             w_behind;
    logic             w_in_move;
    logic             w_in_door;
    logic             w_door_press;
    logic             w_hold;
    logic             w_travel_tc;
    logic             w_door_tc;
    logic             w_door_done;

    assign w_btn = ~{sp_outbtn3, sp_outbtn2_down, sp_outbtn2_up, sp_outbtn1,
                     sp_inbtn3, sp_inbtn2, sp_inbtn1};

    assign w_up         = (r_dir == DIR_UP);
    assign w_in_move    = (r_state == ST_MOVE);
    assign w_in_door    = (r_state == ST_DOOR);
    assign w_here_bits  = floor_bits(r_story);
    assign w_next_floor = w_up ? r_story + 3'd1 : r_story - 3'd1;
    assign w_ahead      = |(r_req & beyond_bits(r_story, w_up));
    assign w_behind     = |(r_req & beyond_bits(r_story, !w_up));
    assign w_clr_here   = clear_mask(r_req, r_story, w_up);
    assign w_clr_next   = clear_mask(r_req, w_next_floor, w_up);

    // Calls for the floor the door is open at are swallowed and only re-arm the door timer.
    assign w_door_press = w_in_door && |(w_btn & w_here_bits);
    assign w_set        = w_in_door ? (w_btn & ~w_here_bits) : w_btn;

`ifdef ELEV_DOOR_HOLD_EN
    assign w_hold = w_in_door && !door_hold_n;
`else
    assign w_hold = 1'b0;
`endif

    assign w_door_done = w_door_tc && !w_door_press && !w_hold;

    always_comb begin
        w_clr = '0;
        if (r_state == ST_IDLE && |w_clr_here)
            w_clr = w_clr_here;
        else if (w_in_move && w_travel_tc)
            w_clr = w_clr_next;
    end

    elev_timer #(.LIMIT(TRAVEL_CYC)) u_travel (
        .clk       (clk),
        .rst       (rst),
        .i_restart (!w_in_move || w_travel_tc),
        .i_en      (w_in_move),
        .o_tc      (w_travel_tc)
    );

    elev_timer #(.LIMIT(DOOR_CYC)) u_door (
        .clk       (clk),
        .rst       (rst),
        .i_restart (!w_in_door || w_door_tc || w_door_press || w_hold),
        .i_en      (w_in_door),
        .o_tc      (w_door_tc)
    );

    // IDLE opens the door only for calls it can clear, so a floor-2 hall call against
    // pending work ahead waits for the return trip instead of cycling the door forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_UP;
            r_story <= FLOOR_MIN;
            r_req   <= '0;
        end else begin
            r_req <= (r_req | w_set) & ~w_clr;
            case (r_state)
                ST_IDLE: begin
                    if (|w_clr_here) begin
                        r_state <= ST_DOOR;
                    end else if (w_ahead) begin
                        r_state <= ST_MOVE;
                    end else if (w_behind) begin
                        r_dir   <= ~r_dir;
                        r_state <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (w_travel_tc) begin
                        r_story <= w_next_floor;
                        if (|w_clr_next)
                            r_state <= ST_DOOR;
                    end
                end
                ST_DOOR: begin
                    if (w_door_done)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign story     = r_story;
    assign req       = r_req;
    assign turn_up   = w_in_move && w_up;
    assign turn_down = w_in_move && !w_up;
    assign door_open = w_in_door;

    a_no_up_from_top: assert property (@(posedge clk) disable iff (rst)
        !(w_in_move && w_up && r_story == FLOOR_MAX));
    a_no_down_from_bottom: assert property (@(posedge clk) disable iff (rst)
        !(w_in_move && !w_up && r_story == FLOOR_MIN));
    a_story_range: assert property (@(posedge clk) disable iff (rst)
        (r_story >= FLOOR_MIN) && (r_story <= FLOOR_MAX));

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed scenarios for elevator_ctrl with TRAVEL_CYC=4, DOOR_CYC=3.
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sp_inbtn1 = 1'b1;
    logic       sp_inbtn2 = 1'b1;
    logic       sp_inbtn3 = 1'b1;
    logic       sp_outbtn1 = 1'b1;
    logic       sp_outbtn2_up = 1'b1;
    logic       sp_outbtn2_down = 1'b1;
    logic       sp_outbtn3 = 1'b1;
`ifdef ELEV_DOOR_HOLD_EN
    logic       door_hold_n = 1'b1;
`endif
    logic [2:0] story;
    logic       turn_up;
    logic       turn_down;
    logic       door_open;
    logic [6:0] req;

    int checks = 0;
    int errors = 0;
    int both_hi = 0;

    elevator_ctrl #(.TRAVEL_CYC(4), .DOOR_CYC(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .sp_inbtn1       (sp_inbtn1),
        .sp_inbtn2       (sp_inbtn2),
        .sp_inbtn3       (sp_inbtn3),
        .sp_outbtn1      (sp_outbtn1),
        .sp_outbtn2_up   (sp_outbtn2_up),
        .sp_outbtn2_down (sp_outbtn2_down),
        .sp_outbtn3      (sp_outbtn3),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold_n     (door_hold_n),
`endif
        .story           (story),
        .turn_up         (turn_up),
        .turn_down       (turn_down),
        .door_open       (door_open),
        .req             (req)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (turn_up && turn_down) both_hi++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the buttons selected by m low for exactly one clock edge (bit order = req).
    task automatic press_mask(input logic [6:0] m);
        sp_inbtn1       = ~m[0];
        sp_inbtn2       = ~m[1];
        sp_inbtn3       = ~m[2];
        sp_outbtn1      = ~m[3];
        sp_outbtn2_up   = ~m[4];
        sp_outbtn2_down = ~m[5];
        sp_outbtn3      = ~m[6];
        tick();
        sp_inbtn1 = 1'b1; sp_inbtn2 = 1'b1; sp_inbtn3 = 1'b1; sp_outbtn1 = 1'b1;
        sp_outbtn2_up = 1'b1; sp_outbtn2_down = 1'b1; sp_outbtn3 = 1'b1;
    endtask

    task automatic wait_door(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!door_open && cyc < 200);
        if (!door_open) cyc = -1;
    endtask

    task automatic wait_closed(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (door_open && cyc < 200);
        if (door_open) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (story !== 3'd1) begin errors++; $display("FAIL reset_story got %0d want 1", story); end
        checks++;
        if (req !== 7'b0) begin errors++; $display("FAIL reset_req got %b want 0000000", req); end
        checks++;
        if ({turn_up, turn_down, door_open} !== 3'b000) begin
            errors++; $display("FAIL reset_outputs got %b want 000", {turn_up, turn_down, door_open});
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({story, req, turn_up, turn_down, door_open} !== {3'd1, 7'b0, 3'b000}) begin
            errors++; $display("FAIL reset_release_idle got story=%0d req=%b outs=%b want 1/0/000",
                               story, req, {turn_up, turn_down, door_open});
        end
    endtask

    task automatic test_car_call();
        int up_cnt;
        int c;
        press_mask(7'b0000100);
        checks++;
        if (req !== 7'b0000100) begin errors++; $display("FAIL car_latch got %b want 0000100", req); end
        checks++;
        if (turn_up !== 1'b0) begin errors++; $display("FAIL car_idle_registered turn_up=%b want 0", turn_up); end
        up_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (turn_up === 1'b1) up_cnt++;
            if (i == 4) begin
                checks++;
                if (story !== 3'd2) begin errors++; $display("FAIL car_mid_story got %0d want 2", story); end
            end
        end
        tick();
        checks++;
        if (up_cnt !== 8) begin errors++; $display("FAIL car_up_cycles got %0d want 8", up_cnt); end
        checks++;
        if ({story, door_open, turn_up} !== {3'd3, 1'b1, 1'b0}) begin
            errors++; $display("FAIL car_arrive got story=%0d door=%b up=%b want 3/1/0", story, door_open, turn_up);
        end
        checks++;
        if (req !== 7'b0) begin errors++; $display("FAIL car_req_clear got %b want 0000000", req); end
        wait_closed(c);
        checks++;
        if (c !== 3) begin errors++; $display("FAIL car_door_cycles got %0d want 3", c); end
    endtask

    task automatic test_floor2_filter();
        int c;
        press_mask(7'b0000001);
        wait_door(c);
        checks++;
        if (c !== 9 || story !== 3'd1) begin
            errors++; $display("FAIL f2_go_floor1 got cyc=%0d story=%0d want 9/1", c, story);
        end
        wait_closed(c);
        press_mask(7'b0100100);
        checks++;
        if (req !== 7'b0100100) begin errors++; $display("FAIL f2_latch got %b want 0100100", req); end
        wait_door(c);
        checks++;
        if (c !== 9 || story !== 3'd3) begin
            errors++; $display("FAIL f2_no_stop got cyc=%0d story=%0d want 9/3", c, story);
        end
        checks++;
        if (req !== 7'b0100000) begin errors++; $display("FAIL f2_pending_down got %b want 0100000", req); end
        wait_closed(c);
        wait_door(c);
        checks++;
        if (c !== 5 || story !== 3'd2) begin
            errors++; $display("FAIL f2_return_stop got cyc=%0d story=%0d want 5/2", c, story);
        end
        checks++;
        if (req !== 7'b0) begin errors++; $display("FAIL f2_down_cleared got %b want 0000000", req); end
        wait_closed(c);
    endtask

    task automatic test_same_floor();
        int c;
        press_mask(7'b0010000);
        checks++;
        if (req !== 7'b0010000) begin errors++; $display("FAIL same_latch got %b want 0010000", req); end
        tick();
        checks++;
        if (door_open !== 1'b1 || req !== 7'b0) begin
            errors++; $display("FAIL same_open got door=%b req=%b want 1/0000000", door_open, req);
        end
        tick();
        press_mask(7'b0010000);
        checks++;
        if (req !== 7'b0 || door_open !== 1'b1) begin
            errors++; $display("FAIL same_repress got door=%b req=%b want 1/0000000", door_open, req);
        end
        wait_closed(c);
        checks++;
        if (c !== 3) begin errors++; $display("FAIL same_restart got %0d want 3", c); end
    endtask

    task automatic test_direction();
        int c;
        press_mask(7'b0000001);
        wait_door(c);
        checks++;
        if (c !== 5 || story !== 3'd1) begin
            errors++; $display("FAIL dir_setup1 got cyc=%0d story=%0d want 5/1", c, story);
        end
        wait_closed(c);
        press_mask(7'b0000010);
        wait_door(c);
        checks++;
        if (c !== 5 || story !== 3'd2) begin
            errors++; $display("FAIL dir_setup2 got cyc=%0d story=%0d want 5/2", c, story);
        end
        press_mask(7'b0000101);
        checks++;
        if (req !== 7'b0000101) begin errors++; $display("FAIL dir_latch got %b want 0000101", req); end
        wait_closed(c);
        checks++;
        if (c !== 2) begin errors++; $display("FAIL dir_door_rest got %0d want 2", c); end
        wait_door(c);
        checks++;
        if (c !== 5 || story !== 3'd3 || req !== 7'b0000001) begin
            errors++; $display("FAIL dir_up_first got cyc=%0d story=%0d req=%b want 5/3/0000001", c, story, req);
        end
        wait_closed(c);
        wait_door(c);
        checks++;
        if (c !== 9 || story !== 3'd1 || req !== 7'b0) begin
            errors++; $display("FAIL dir_then_down got cyc=%0d story=%0d req=%b want 9/1/0000000", c, story, req);
        end
        wait_closed(c);
        checks++;
        if (both_hi !== 0) begin errors++; $display("FAIL dir_both_turn got %0d want 0", both_hi); end
    endtask

    task automatic test_reset_mid();
        press_mask(7'b0000100);
        repeat (5) tick();
        checks++;
        if (story !== 3'd2 || turn_up !== 1'b1 || req !== 7'b0000100) begin
            errors++; $display("FAIL rstmid_pre got story=%0d up=%b req=%b want 2/1/0000100", story, turn_up, req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (story !== 3'd1 || req !== 7'b0) begin
            errors++; $display("FAIL rstmid_async got story=%0d req=%b want 1/0000000", story, req);
        end
        checks++;
        if ({turn_up, turn_down, door_open} !== 3'b000) begin
            errors++; $display("FAIL rstmid_outs got %b want 000", {turn_up, turn_down, door_open});
        end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({story, turn_up, turn_down, door_open} !== {3'd1, 3'b000}) begin
            errors++; $display("FAIL rstmid_after got story=%0d outs=%b want 1/000",
                               story, {turn_up, turn_down, door_open});
        end
    endtask

`ifdef ELEV_DOOR_HOLD_EN
    task automatic test_door_hold();
        int c;
        int held;
        press_mask(7'b0000001);
        tick();
        door_hold_n = 1'b0;
        held = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (door_open === 1'b1) held++;
        end
        door_hold_n = 1'b1;
        checks++;
        if (held !== 10) begin errors++; $display("FAIL hold_open got %0d want 10", held); end
        wait_closed(c);
        checks++;
        if (c !== 3) begin errors++; $display("FAIL hold_release got %0d want 3", c); end
    endtask
`endif

    initial begin
        test_reset();
        test_car_call();
        test_floor2_filter();
        test_same_floor();
        test_direction();
        test_reset_mid();
`ifdef ELEV_DOOR_HOLD_EN
        test_door_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
